// File: rtl/fft_framer_pkg.sv
// rtl/fft_framer_pkg.sv - shared state encoding, config word layout and builder
package fft_framer_pkg;

    localparam int CFG_W_DEF     = 24;
    localparam int SCALE_W_DEF   = 14;
    localparam int CFG_NFFT_LSB  = 0;
    localparam int CFG_NFFT_W    = 5;
    localparam int CFG_FWD_BIT   = 8;
    localparam int CFG_SCALE_LSB = 9;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND_CFG = 2'd1;
    localparam logic [1:0] ST_STREAM   = 2'd2;

    // Bits [7:5] and everything above the scale field stay zero.
    function automatic logic [CFG_W_DEF-1:0] build_cfg_word(
        input logic [CFG_NFFT_W-1:0]  nfft,
        input logic                   fwd_inv,
        input logic [SCALE_W_DEF-1:0] scale
    );
        logic [CFG_W_DEF-1:0] w;
        w = '0;
        w[CFG_NFFT_LSB +: CFG_NFFT_W]   = nfft;
        w[CFG_FWD_BIT]                  = fwd_inv;
        w[CFG_SCALE_LSB +: SCALE_W_DEF] = scale;
        return w;
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// rtl/fft_beat_counter.sv - frame beat counter with loadable terminal count
module fft_beat_counter
    import fft_framer_pkg::*;
#(
    parameter int CNT_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] term_i,
    input  logic             inc_i,
    output logic             is_last_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] term_q;

    assign is_last_o = (count_q == term_q);
    assign wrap_o    = inc_i && is_last_o;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = is_last_o ? '0 : count_q + CNT_W'(1);
        end
    end

    // A new terminal may load on the same edge the old frame wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            term_q  <= '0;
        end else begin
            count_q <= count_d;
            if (load_i) begin
                term_q <= term_i;
            end
        end
    end

endmodule

// File: rtl/fft_stream_framer.sv
// rtl/fft_stream_framer.sv - frames DMA samples for the FFT core and issues config words
module fft_stream_framer
    import fft_framer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NLOG2_MIN = 3,
    parameter int NLOG2_MAX = 13,
    parameter int SCALE_W   = SCALE_W_DEF,
    parameter int CFG_W     = CFG_W_DEF
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic [4:0]        cfg_nfft_log2,
    input  logic              cfg_fwd_inv,
    input  logic [SCALE_W-1:0] cfg_scale_sch,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    output logic              m_axis_data_tlast,
    input  logic              m_axis_data_tready,
    output logic [CFG_W-1:0]  m_axis_cfg_tdata,
    output logic              m_axis_cfg_tvalid,
    input  logic              m_axis_cfg_tready,
    output logic [31:0]       frame_count,
    output logic              err_early_last,
    output logic              err_missing_last,
    output logic              busy
);

    logic [1:0]           state_q, state_d;
    logic [CFG_W-1:0]     cur_cfg_q, cur_cfg_d;
    logic [CFG_W-1:0]     last_cfg_q, last_cfg_d;
    logic                 cfg_sent_valid_q, cfg_sent_valid_d;
    logic [31:0]          frame_count_q;
    logic                 err_early_q, err_missing_q;

    logic [4:0]           nfft_cl;
    logic [CFG_W-1:0]     new_cfg;
    logic [NLOG2_MAX-1:0] new_term;
    logic                 need_cfg;
    logic                 streaming;
    logic                 accept;
    logic                 is_last;
    logic                 frame_done;
    logic                 latch;

    always_comb begin
        nfft_cl = cfg_nfft_log2;
        if (cfg_nfft_log2 < 5'(NLOG2_MIN)) begin
            nfft_cl = 5'(NLOG2_MIN);
        end else if (cfg_nfft_log2 > 5'(NLOG2_MAX)) begin
            nfft_cl = 5'(NLOG2_MAX);
        end
    end

    assign new_cfg  = build_cfg_word(nfft_cl, cfg_fwd_inv, cfg_scale_sch);
    assign new_term = NLOG2_MAX'((32'd1 << nfft_cl) - 32'd1);
    assign need_cfg = !cfg_sent_valid_q || (new_cfg != last_cfg_q);

    assign streaming          = (state_q == ST_STREAM);
    assign accept             = streaming && s_axis_tvalid && m_axis_data_tready;
    assign s_axis_tready      = streaming && m_axis_data_tready;
    assign m_axis_data_tvalid = streaming && s_axis_tvalid;
    assign m_axis_data_tdata  = s_axis_tdata;
    assign m_axis_data_tlast  = streaming && is_last;
    assign m_axis_cfg_tvalid  = (state_q == ST_SEND_CFG);
    assign m_axis_cfg_tdata   = cur_cfg_q;
    assign frame_count        = frame_count_q;
    assign err_early_last     = err_early_q;
    assign err_missing_last   = err_missing_q;
    assign busy               = (state_q != ST_IDLE);

    fft_beat_counter #(
        .CNT_W (NLOG2_MAX)
    ) u_beat_counter (
        .clk_i     (aclk),
        .rst_i     (areset),
        .load_i    (latch),
        .term_i    (new_term),
        .inc_i     (accept),
        .is_last_o (is_last),
        .wrap_o    (frame_done)
    );

    always_comb begin
        state_d          = state_q;
        cur_cfg_d        = cur_cfg_q;
        last_cfg_d       = last_cfg_q;
        cfg_sent_valid_d = cfg_sent_valid_q;
        latch            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    latch   = 1'b1;
                    state_d = need_cfg ? ST_SEND_CFG : ST_STREAM;
                end
            end
            ST_SEND_CFG: begin
                if (m_axis_cfg_tready) begin
                    last_cfg_d       = cur_cfg_q;
                    cfg_sent_valid_d = 1'b1;
                    state_d          = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Settings only take effect at a frame boundary.
                if (frame_done) begin
                    if (enable) begin
                        latch   = 1'b1;
                        state_d = need_cfg ? ST_SEND_CFG : ST_STREAM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (latch) begin
            cur_cfg_d = new_cfg;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q          <= ST_IDLE;
            cur_cfg_q        <= '0;
            last_cfg_q       <= '0;
            cfg_sent_valid_q <= 1'b0;
            frame_count_q    <= '0;
            err_early_q      <= 1'b0;
            err_missing_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cur_cfg_q        <= cur_cfg_d;
            last_cfg_q       <= last_cfg_d;
            cfg_sent_valid_q <= cfg_sent_valid_d;
            if (frame_done) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
            err_early_q   <= accept && s_axis_tlast && !is_last;
            err_missing_q <= accept && !s_axis_tlast && is_last;
        end
    end

endmodule

// File: doc/fft_stream_framer.md
Name: fft_stream_framer

Overview:
Sits in the PL between the AXI DMA MM2S stream output and the FFT core's data and config slave ports.
- Chops the incoming sample stream into frames of exactly 2^nfft_log2 beats and regenerates tlast on the last beat of each frame.
- Issues the FFT config word on its own handshake before a frame whenever the settings have changed.
- Flags DMA packets whose tlast does not line up with the FFT frame boundary.

Parameters:
DATA_W, 32, sample width (16-bit re/im packed).
NLOG2_MIN, 3, smallest supported log2 transform length.
NLOG2_MAX, 13, largest supported log2 transform length.
SCALE_W, 14, width of the FFT scale schedule field.
CFG_W, 24, config tdata width: {zero pad, scale_sch, fwd_inv, 3'b0, nfft[4:0]}, LSB first.

Ports:
aclk  in  1  the single clock.
areset  in  1  synchronous reset, active-high.
enable  in  1  allows new frames to start.
cfg_nfft_log2  in  5  requested log2 transform length.
cfg_fwd_inv  in  1  1 = forward transform.
cfg_scale_sch  in  SCALE_W  scale schedule.
s_axis_tdata  in  DATA_W  DMA sample data.
s_axis_tvalid  in  1  DMA sample valid.
s_axis_tlast  in  1  DMA packet end.
s_axis_tready  out  1  ready back to DMA.
m_axis_data_tdata  out  DATA_W  sample data to FFT.
m_axis_data_tvalid  out  1  data valid to FFT.
m_axis_data_tlast  out  1  regenerated frame end.
m_axis_data_tready  in  1  FFT data ready.
m_axis_cfg_tdata  out  CFG_W  config word.
m_axis_cfg_tvalid  out  1  config valid.
m_axis_cfg_tready  in  1  FFT config ready.
frame_count  out  32  completed frames, wraps at 2^32.
err_early_last  out  1  one-cycle pulse: input tlast before frame end.
err_missing_last  out  1  one-cycle pulse: no input tlast on frame end.
busy  out  1  high when state is not IDLE.

Behaviour:
Reset and clocking:
- Clock and reset: one clock `aclk`; reset `areset` is synchronous and active-high.
- Reset values: state=IDLE; beat counter 0; frame_count 0; both err pulses 0; m_axis_cfg_tvalid 0; busy 0; cfg_sent_valid 0.
- Reset asserted mid-frame aborts the frame immediately and forces the reset values on the next edge. Any partially forwarded frame is the FFT's problem; the block does not drain it.

State machine:
- IDLE: if enable=1, latch the cfg_* inputs into the cur_cfg register.
  - nfft is clamped to [NLOG2_MIN, NLOG2_MAX] at latch time.
  - Go to SEND_CFG if cfg_sent_valid=0 or cur_cfg differs from last_cfg; otherwise go to STREAM.
- SEND_CFG: m_axis_cfg_tvalid=1 and tdata=cur_cfg, held stable until m_axis_cfg_tready.
  - On handshake: last_cfg<=cur_cfg, cfg_sent_valid<=1, go to STREAM.
- STREAM: combinational pass-through with zero latency.
  - m_axis_data_tvalid = s_axis_tvalid.
  - s_axis_tready = m_axis_data_tready.
  - tdata is passed unchanged.
  - A beat is counted only when m_axis_data_tvalid and m_axis_data_tready are both high.
  - m_axis_data_tlast = (count == 2^nfft-1).
  - On the last beat: count<=0, frame_count++; if enable=1, re-latch cfg and go to SEND_CFG or STREAM by the same rule as IDLE; else go to IDLE.
- Outside STREAM: s_axis_tready=0 and m_axis_data_tvalid=0.

Error checks and edge cases:
- Alignment checks are evaluated on accepted beats only:
  - s_axis_tlast=1 with count < N-1 gives an err_early_last pulse. Framing ignores the input tlast and the frame continues.
  - s_axis_tlast=0 with count == N-1 gives an err_missing_last pulse.
- Dropping enable mid-frame completes the current frame and then returns to IDLE.
- cfg_* inputs changing mid-frame have no effect until the next frame start.

Decomposition:
- Package fft_framer_pkg: state enum (IDLE, SEND_CFG, STREAM), the CFG_W field offsets, and function build_cfg_word(nfft, fwd_inv, scale).
- One sub-module, fft_beat_counter: loadable terminal count, increment-on-handshake, and the is_last and wrap outputs.

Test Plan:
1. Reset, enable=1, nfft=4, fwd=1, scale=0x2AB, cfg_tready=1 → exactly one cfg beat with tdata=0x0557_04 (scale<<9 | fwd<<8 | 4). Then 16 beats pass through with tlast on beat 16 only, and frame_count=1.
2. Three back-to-back 16-beat frames with unchanged cfg → no further cfg beats, and frame_count=3. Change to nfft=5 before frame 4 → one new cfg beat, and the next frame is 32 beats.
3. m_axis_cfg_tready held low for 10 cycles → cfg_tvalid high and tdata stable throughout, and s_axis_tready=0 until the handshake completes.
4. DMA packet of 12 beats with tlast on beat 12, nfft=4 → err_early_last pulses on beat 12, and m_axis tlast appears on beat 16. A packet with no tlast on beat 16 → err_missing_last pulses on beat 16.
5. Random m_axis_data_tready and s_axis_tvalid, nfft=3 → data order is preserved, every 8th accepted beat carries tlast, and no beat is duplicated or lost.
6. areset pulsed at beat 7 of a 16-beat frame → every output takes its reset value on the next edge, and the following frame re-sends cfg.
